// File: rtl/ball_possession_arbiter_if.sv
// ---------------------------------------------------------------------------
// ball_possession_arbiter_if
// Groups the signals between glove tracking / ball physics and the possession
// arbiter into one bundle.
//
// Signals
//   glove1closed, glove2closed : hand-closed levels from glove tracking
//   near1, near2               : ball within catch tolerance of each glove
//   respawn                    : request to spawn the ball into a closed glove
//   tick                       : one-cycle physics update strobe
//   ball_state                 : 0 free, 1 held by glove1, 2 held by glove2
//   catch_pulse                : one cycle on a catch or steal
//   release_pulse              : one cycle on a held -> free change
//
// Modports
//   master : the side that drives glove/near/respawn and observes the results
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface ball_possession_arbiter_if;

    logic       glove1closed;
    logic       glove2closed;
    logic       near1;
    logic       near2;
    logic       respawn;
    logic       tick;
    logic [1:0] ball_state;
    logic       catch_pulse;
    logic       release_pulse;

    modport master (
        output glove1closed, glove2closed, near1, near2, respawn,
        input  tick, ball_state, catch_pulse, release_pulse
    );

    modport slave (
        input  glove1closed, glove2closed, near1, near2, respawn,
        output tick, ball_state, catch_pulse, release_pulse
    );

endinterface

// File: rtl/ball_possession_arbiter.sv
// ---------------------------------------------------------------------------
// ball_possession_arbiter
// Owns the game update tick and decides who holds the ball: free (in flight),
// glove1 or glove2. Arbitrates catches, releases and respawns, and emits
// one-cycle catch/release events so the physics datapath can latch position
// and velocity.
//
// Parameters
//   TICK_DIV       : clk cycles per update tick (>= 2)
//   ARM_TICKS      : ticks a glove stays armed after it was last seen open
//   HOLD_MIN_TICKS : ticks the ball must be held before an open glove releases
//
// Ports
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : ball_possession_arbiter_if.slave (glove/near/respawn in,
//           tick/ball_state/catch_pulse/release_pulse out)
//
// Build option
//   BALL_STEAL_EN : when defined, the non-holding glove may steal the ball
//                   from the holder on a tick. Undefined by default.
// ---------------------------------------------------------------------------
module ball_possession_arbiter #(
    parameter int TICK_DIV       = 210937,
    parameter int ARM_TICKS      = 64,
    parameter int HOLD_MIN_TICKS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    ball_possession_arbiter_if.slave    bus
);

    localparam int                 DIV_W      = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]   DIV_RELOAD = DIV_W'(TICK_DIV - 1);
    localparam logic [7:0]         ARM_LOAD   = 8'(ARM_TICKS);
    localparam logic [7:0]         HOLD_MIN   = 8'(HOLD_MIN_TICKS);

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        HELD1 = 2'd1,
        HELD2 = 2'd2,
        BAD   = 2'd3
    } state_t;

    logic [DIV_W-1:0] div_q;
    logic             tick_q;

    state_t           state_q, state_d;
    logic [7:0]       arm1_q, arm1_d;
    logic [7:0]       arm2_q, arm2_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       hold_inc;
    logic             rr_q, rr_d;
    logic             catch_q, catch_d;
    logic             release_q, release_d;

    logic             catch1, catch2, grant1;

    // Tick divider: counts down from TICK_DIV-1; the cycle after it hits zero
    // the registered tick is high for exactly one cycle. All game decisions
    // are qualified by this registered tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= DIV_RELOAD;
            tick_q <= 1'b0;
        end else if (div_q == '0) begin
            div_q  <= DIV_RELOAD;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q - 1'b1;
            tick_q <= 1'b0;
        end
    end

    // A glove can catch only if it is closed, near the ball and was seen open
    // recently enough that its arm counter has not run out.
    assign catch1   = bus.glove1closed & (arm1_q != 8'd0) & bus.near1;
    assign catch2   = bus.glove2closed & (arm2_q != 8'd0) & bus.near2;
    // rr_q = 0 prefers glove1 on a simultaneous catch, rr_q = 1 prefers glove2.
    assign grant1   = catch1 & (~catch2 | ~rr_q);
    assign hold_inc = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;

    // Next-state logic. Arm counters follow the glove levels on every tick;
    // a winning catch then overrides the winner's counter to zero so the same
    // closed hand cannot immediately re-catch. Respawn acts on any cycle and
    // wins over a catch. The hold count includes the current tick, so with
    // HOLD_MIN_TICKS = 2 the ball can leave on the second tick after a catch.
    always_comb begin
        state_d   = state_q;
        arm1_d    = arm1_q;
        arm2_d    = arm2_q;
        hold_d    = hold_q;
        rr_d      = rr_q;
        catch_d   = 1'b0;
        release_d = 1'b0;

        if (tick_q) begin
            if (!bus.glove1closed) begin
                arm1_d = ARM_LOAD;
            end else if (arm1_q != 8'd0) begin
                arm1_d = arm1_q - 8'd1;
            end
            if (!bus.glove2closed) begin
                arm2_d = ARM_LOAD;
            end else if (arm2_q != 8'd0) begin
                arm2_d = arm2_q - 8'd1;
            end
        end

        case (state_q)
            FREE: begin
                if (bus.respawn) begin
                    if (bus.glove1closed) begin
                        state_d = HELD1;
                        hold_d  = 8'd0;
                    end else if (bus.glove2closed) begin
                        state_d = HELD2;
                        hold_d  = 8'd0;
                    end
                end else if (tick_q && (catch1 || catch2)) begin
                    catch_d = 1'b1;
                    hold_d  = 8'd0;
                    if (catch1 && catch2) begin
                        rr_d = grant1;
                    end
                    if (grant1) begin
                        state_d = HELD1;
                        arm1_d  = 8'd0;
                    end else begin
                        state_d = HELD2;
                        arm2_d  = 8'd0;
                    end
                end
            end

            HELD1: begin
                if (tick_q) begin
                    hold_d = hold_inc;
`ifdef BALL_STEAL_EN
                    if (catch2) begin
                        state_d = HELD2;
                        catch_d = 1'b1;
                        arm2_d  = 8'd0;
                        hold_d  = 8'd0;
                    end else
`endif
                    if (!bus.glove1closed && (hold_inc >= HOLD_MIN)) begin
                        state_d   = FREE;
                        release_d = 1'b1;
                    end
                end
            end

            HELD2: begin
                if (tick_q) begin
                    hold_d = hold_inc;
`ifdef BALL_STEAL_EN
                    if (catch1) begin
                        state_d = HELD1;
                        catch_d = 1'b1;
                        arm1_d  = 8'd0;
                        hold_d  = 8'd0;
                    end else
`endif
                    if (!bus.glove2closed && (hold_inc >= HOLD_MIN)) begin
                        state_d   = FREE;
                        release_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = FREE;
            end
        endcase
    end

    // State, counters and event pulses. The pulses are registered together
    // with the state so they line up with the cycle the new state appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FREE;
            arm1_q    <= 8'd0;
            arm2_q    <= 8'd0;
            hold_q    <= 8'd0;
            rr_q      <= 1'b0;
            catch_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm1_q    <= arm1_d;
            arm2_q    <= arm2_d;
            hold_q    <= hold_d;
            rr_q      <= rr_d;
            catch_q   <= catch_d;
            release_q <= release_d;
        end
    end

    assign bus.tick          = tick_q;
    assign bus.ball_state    = state_q;
    assign bus.catch_pulse   = catch_q;
    assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_ball_possession_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ball_possession_arbiter
// Self-checking bench for ball_possession_arbiter with TICK_DIV=4,
// ARM_TICKS=4, HOLD_MIN_TICKS=2. A cycle-by-cycle vector table covers the
// tick cadence, a single catch, the hold debounce/release and arm expiry;
// hand-written sequences cover simultaneous catches, respawn, async reset
// mid-hold and stealing (expectation depends on BALL_STEAL_EN).
// ---------------------------------------------------------------------------
module tb_ball_possession_arbiter;

    localparam int TB_TICK_DIV = 4;

    typedef struct {
        logic       g1c;
        logic       g2c;
        logic       n1;
        logic       n2;
        logic       resp;
        logic [1:0] exp_state;
        logic       exp_catch;
        logic       exp_release;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    ball_possession_arbiter_if bus ();

    ball_possession_arbiter #(
        .TICK_DIV       (TB_TICK_DIV),
        .ARM_TICKS      (4),
        .HOLD_MIN_TICKS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic g1c, input logic g2c,
                                 input logic n1, input logic n2,
                                 input logic resp);
        bus.glove1closed = g1c;
        bus.glove2closed = g2c;
        bus.near1        = n1;
        bus.near2        = n2;
        bus.respawn      = resp;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic add_span(input int count, input logic g1c, input logic g2c,
                            input logic n1, input logic n2, input logic resp,
                            input logic [1:0] st, input logic c, input logic r);
        for (int k = 0; k < count; k++) begin
            vecs.push_back('{g1c, g2c, n1, n2, resp, st, c, r});
        end
    endtask

    // Holds reset for two cycles, checks the reset outputs, releases on a
    // falling edge so the next rising edge is cycle 1.
    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset ball_state", bus.ball_state, 0);
        checkOutput("reset tick", bus.tick, 0);
        checkOutput("reset catch_pulse", bus.catch_pulse, 0);
        checkOutput("reset release_pulse", bus.release_pulse, 0);
        reset = 1'b0;
    endtask

    // Advances to the next falling edge where tick is high (bounded).
    task automatic waitTick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tick !== 1'b1 && n < 3 * TB_TICK_DIV);
        if (bus.tick !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s tick wait: got no tick required tick", name);
        end
    endtask

    // Drives inputs for the decision edge of the next tick and steps past it.
    task automatic tickStep(input string name, input logic g1c, input logic g2c,
                            input logic n1, input logic n2);
        waitTick(name);
        applyStimulus(g1c, g2c, n1, n2, 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        applyStimulus(0, 0, 0, 0, 0);

        // Entry e drives the inputs for rising edge e+1 and is checked after
        // it. Tick is visible after edges 4, 8, 12..., so entries 4, 8, 12...
        // carry the inputs the arbiter decides on.
        add_span(8,  0, 0, 0, 0, 0,  2'd0, 0, 0);  // idle, gloves open: arm both
        add_span(1,  1, 0, 1, 0, 0,  2'd1, 1, 0);  // closed + near: catch
        add_span(3,  1, 0, 1, 0, 0,  2'd1, 0, 0);
        add_span(4,  0, 0, 0, 0, 0,  2'd1, 0, 0);  // open 1 tick after catch: debounce
        add_span(1,  0, 0, 0, 0, 0,  2'd0, 0, 1);  // tick 2: release
        add_span(3,  0, 0, 0, 0, 0,  2'd0, 0, 0);
        add_span(16, 1, 0, 0, 0, 0,  2'd0, 0, 0);  // closed 4 ticks: arm runs out
        add_span(4,  1, 0, 1, 0, 0,  2'd0, 0, 0);  // near on 5th closed tick: no catch

        doReset();
        for (int e = 0; e < vecs.size(); e++) begin
            applyStimulus(vecs[e].g1c, vecs[e].g2c, vecs[e].n1, vecs[e].n2, vecs[e].resp);
            @(negedge clk);
            checkOutput($sformatf("vec%0d tick", e), bus.tick,
                        (((e + 1) % TB_TICK_DIV) == 0) ? 1 : 0);
            checkOutput($sformatf("vec%0d ball_state", e), bus.ball_state, vecs[e].exp_state);
            checkOutput($sformatf("vec%0d catch_pulse", e), bus.catch_pulse, vecs[e].exp_catch);
            checkOutput($sformatf("vec%0d release_pulse", e), bus.release_pulse, vecs[e].exp_release);
        end

        // Simultaneous catches alternate, glove1 first after reset.
        doReset();
        tickStep("tie arm", 0, 0, 0, 0);
        checkOutput("tie arm ball_state", bus.ball_state, 0);
        tickStep("tie1", 1, 1, 1, 1);
        checkOutput("tie1 ball_state", bus.ball_state, 1);
        checkOutput("tie1 catch_pulse", bus.catch_pulse, 1);
        checkOutput("tie1 release_pulse", bus.release_pulse, 0);
        @(negedge clk);
        checkOutput("tie1 catch width", bus.catch_pulse, 0);
        tickStep("tie hold", 0, 0, 0, 0);
        checkOutput("tie hold ball_state", bus.ball_state, 1);
        tickStep("tie release", 0, 0, 0, 0);
        checkOutput("tie release ball_state", bus.ball_state, 0);
        checkOutput("tie release pulse", bus.release_pulse, 1);
        tickStep("tie2", 1, 1, 1, 1);
        checkOutput("tie2 ball_state", bus.ball_state, 2);
        checkOutput("tie2 catch_pulse", bus.catch_pulse, 1);

        // Respawn while held is ignored.
        applyStimulus(1, 1, 0, 0, 1);
        repeat (2 * TB_TICK_DIV) @(negedge clk);
        checkOutput("respawn held ball_state", bus.ball_state, 2);
        checkOutput("respawn held catch_pulse", bus.catch_pulse, 0);

        // Let glove2 open to drop the ball, then respawn into glove2.
        applyStimulus(0, 0, 0, 0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ball_state !== 2'd0 && n < 3 * TB_TICK_DIV);
        checkOutput("drop ball_state", bus.ball_state, 0);
        checkOutput("drop release_pulse", bus.release_pulse, 1);
        applyStimulus(0, 1, 0, 0, 1);
        @(negedge clk);
        checkOutput("respawn ball_state", bus.ball_state, 2);
        checkOutput("respawn catch_pulse", bus.catch_pulse, 0);
        applyStimulus(0, 1, 0, 0, 0);

        // Async reset in the middle of a hold.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset ball_state", bus.ball_state, 0);
        checkOutput("async reset release_pulse", bus.release_pulse, 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tick !== 1'b1 && n < 3 * TB_TICK_DIV);
        checkOutput("divider restart cycles", n, TB_TICK_DIV);

        // Steal: glove1 holds via respawn, glove2 gets armed then closes near.
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("steal setup ball_state", bus.ball_state, 1);
        applyStimulus(1, 0, 0, 0, 0);
        tickStep("steal arm", 1, 0, 0, 0);
        checkOutput("steal arm ball_state", bus.ball_state, 1);
        tickStep("steal", 1, 1, 0, 1);
`ifdef BALL_STEAL_EN
        checkOutput("steal ball_state", bus.ball_state, 2);
        checkOutput("steal catch_pulse", bus.catch_pulse, 1);
`else
        checkOutput("steal ball_state", bus.ball_state, 1);
        checkOutput("steal catch_pulse", bus.catch_pulse, 0);
`endif
        checkOutput("steal release_pulse", bus.release_pulse, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
